// File: rtl/sram_access_sched_pkg.sv
// rtl/sram_access_sched_pkg.sv - shared state encoding and constants for the SRAM/UART access sequencer
package sram_access_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_U_STAT,
    ST_U_RD_WAIT,
    ST_U_RD,
    ST_U_WR,
    ST_U_WR_WAIT
  } state_e;

  localparam logic [17:0] UART_DATA_ADDR_DFLT = 18'h0BF00;
  localparam logic [17:0] UART_STAT_ADDR_DFLT = 18'h0BF01;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int                    PHASE_CNT_W    = 2;
  localparam logic [PHASE_CNT_W-1:0] U_RD_CYCLES_M1 = 2'd1;

endpackage

// File: rtl/sram_phase_cnt.sv
// rtl/sram_phase_cnt.sv - loadable down-counter timing strobe phase lengths, with zero flag
module sram_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sram_access_sched.sv
// rtl/sram_access_sched.sv - arbitrates IF and MEM ports onto one async SRAM bank and the UART.
// Every output is a flop; strobes are decoded from the next state so they change on clock edges only.
module sram_access_sched
  import sram_access_sched_pkg::*;
#(
  parameter int                ADDR_W         = 18,
  parameter int                DATA_W         = 16,
  parameter int                RD_WAIT        = 1,
  parameter int                WR_PULSE       = 1,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(UART_DATA_ADDR_DFLT),
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(UART_STAT_ADDR_DFLT)
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]       sram_dout_q, sram_dout_d;
  logic [DATA_W-1:0]       if_inst_q, if_inst_d;
  logic [DATA_W-1:0]       mem_rdata_q, mem_rdata_d;
  logic                    if_valid_q, if_valid_d;
  logic                    mem_done_q, mem_done_d;
  logic                    stall_q, stall_d;
  logic                    dout_en_q, dout_en_d;
  logic                    ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                    rdn_q, rdn_d, wrn_q, wrn_d;
  logic                    is_if_q, is_if_d;
  logic                    tbre_seen_q, tbre_seen_d;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [PHASE_CNT_W-1:0]  cnt_val;

  sram_phase_cnt #(.W(PHASE_CNT_W)) u_phase_cnt (
    .clk      (clk_50MHz),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    is_if_d     = is_if_q;
    tbre_seen_d = tbre_seen_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          sram_addr_d = mem_addr;
          is_if_d     = 1'b0;
          if (mem_we) begin
            sram_dout_d = mem_wdata;
            if (mem_addr == UART_DATA_ADDR) begin
              state_d     = ST_U_WR;
              tbre_seen_d = 1'b0;
            end else if (mem_addr == UART_STAT_ADDR) begin
              mem_done_d = 1'b1;
            end else begin
              state_d = ST_WR_SETUP;
            end
          end else if (mem_addr == UART_DATA_ADDR) begin
            state_d = ST_U_RD_WAIT;
          end else if (mem_addr == UART_STAT_ADDR) begin
            state_d = ST_U_STAT;
          end else begin
            state_d  = ST_RD;
            cnt_load = 1'b1;
            cnt_val  = PHASE_CNT_W'(RD_WAIT);
          end
        end else if (if_req) begin
          sram_addr_d = {{(ADDR_W-16){1'b0}}, if_addr};
          is_if_d     = 1'b1;
          state_d     = ST_RD;
          cnt_load    = 1'b1;
          cnt_val     = PHASE_CNT_W'(RD_WAIT);
        end
      end
      ST_RD: begin
        if (cnt_zero) begin
          if (is_if_q) begin
            if_inst_d  = sram_din;
            if_valid_d = 1'b1;
          end else begin
            mem_rdata_d = sram_din;
            mem_done_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        cnt_load = 1'b1;
        cnt_val  = PHASE_CNT_W'(WR_PULSE - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        mem_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_U_STAT: begin
        mem_rdata_d = {{(DATA_W-2){1'b0}}, data_ready, tsre & tbre};
        mem_done_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_U_RD_WAIT: begin
        if (data_ready) begin
          state_d  = ST_U_RD;
          cnt_load = 1'b1;
          cnt_val  = U_RD_CYCLES_M1;
        end
      end
      ST_U_RD: begin
        if (cnt_zero) begin
          mem_rdata_d = sram_din;
          mem_done_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_U_WR: begin
        state_d = ST_U_WR_WAIT;
      end
      ST_U_WR_WAIT: begin
        // tbre must be seen first; a tsre that was already high does not count on its own
        tbre_seen_d = tbre_seen_q | tbre;
        if ((tbre_seen_q | tbre) & tsre) begin
          mem_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ce_n_d    = (state_d inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD}) ? STROBE_ON : STROBE_OFF;
    oe_n_d    = (state_d == ST_RD)        ? STROBE_ON : STROBE_OFF;
    we_n_d    = (state_d == ST_WR_PULSE)  ? STROBE_ON : STROBE_OFF;
    rdn_d     = (state_d == ST_U_RD)      ? STROBE_ON : STROBE_OFF;
    wrn_d     = (state_d == ST_U_WR)      ? STROBE_ON : STROBE_OFF;
    dout_en_d = state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD, ST_U_WR};
    stall_d   = (state_d != ST_IDLE) | if_valid_d | mem_done_d;
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      stall_q     <= 1'b0;
      dout_en_q   <= 1'b0;
      ce_n_q      <= STROBE_OFF;
      oe_n_q      <= STROBE_OFF;
      we_n_q      <= STROBE_OFF;
      rdn_q       <= STROBE_OFF;
      wrn_q       <= STROBE_OFF;
      is_if_q     <= 1'b0;
      tbre_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
      stall_q     <= stall_d;
      dout_en_q   <= dout_en_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      is_if_q     <= is_if_d;
      tbre_seen_q <= tbre_seen_d;
    end
  end

  assign if_inst      = if_inst_q;
  assign if_valid     = if_valid_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_done     = mem_done_q;
  assign stall_o      = stall_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dout    = sram_dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign uart_rdn     = rdn_q;
  assign uart_wrn     = wrn_q;

endmodule

// File: tb/tb_sram_access_sched.sv
// tb/tb_sram_access_sched.sv - self-checking bench for sram_access_sched with SRAM and UART models
module tb_sram_access_sched;

  logic        clk_50MHz, rst;
  logic        if_req, mem_req, mem_we;
  logic [15:0] if_addr, if_inst, mem_wdata, mem_rdata, sram_dout, sram_din, uart_rx, uart_tx;
  logic [17:0] mem_addr, sram_addr;
  logic        if_valid, mem_done, stall_o, sram_dout_en;
  logic        sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn;
  logic        data_ready, tbre, tsre;

  sram_access_sched #(.RD_WAIT(1), .WR_PULSE(2)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_o(stall_o),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  logic [15:0] mem_model [logic [17:0]];

  function automatic logic [15:0] init_val(input logic [17:0] a);
    case (a)
      18'h00040: init_val = 16'h1234;
      18'h00100: init_val = 16'hBEEF;
      18'h0BF00: init_val = 16'h7777;
      18'h3FFFF: init_val = 16'hC0DE;
      default:   init_val = a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk_50MHz)
    if (!sram_ce_n && !sram_we_n && sram_dout_en) mem_model[sram_addr] = sram_dout;

  always @(negedge clk_50MHz) begin
    if (!uart_rdn) sram_din = uart_rx;
    else if (!sram_ce_n && !sram_oe_n)
      sram_din = mem_model.exists(sram_addr) ? mem_model[sram_addr] : init_val(sram_addr);
    else sram_din = 16'h0000;
  end

  int c_ce = 0, c_oe = 0, c_we = 0, c_den = 0, c_rdn = 0, c_wrn = 0, c_done = 0, c_ovl = 0;
  always @(negedge clk_50MHz) begin
    if (!sram_ce_n) c_ce++;
    if (!sram_oe_n) c_oe++;
    if (!sram_we_n) c_we++;
    if (sram_dout_en) c_den++;
    if (!uart_rdn) c_rdn++;
    if (!uart_wrn) begin c_wrn++; uart_tx = sram_dout; end
    if (mem_done) c_done++;
    if (!sram_ce_n && (!uart_rdn || !uart_wrn)) c_ovl++;
  end

  typedef struct packed {
    logic        is_if;
    logic        chk;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        is_if;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        dr, tb, ts;
    logic [15:0] exp;
    int          lat;
    logic [47:0] strobes;
  } vec_t;
  vec_t vecs[11];
  vec_t v;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk_50MHz);
    #1;
    if (if_valid || mem_done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: if_valid=%0b mem_done=%0b expected neither", if_valid, mem_done);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind", {if_valid, mem_done}, e.is_if ? 2'b10 : 2'b01);
        if (e.chk) chk("sb_data", e.is_if ? if_inst : mem_rdata, e.data);
      end
    end
  endtask

  int s_ce, s_oe, s_we, s_den, s_rdn, s_wrn, s_done, lat, st, mem_at, if_at;
  logic got;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    data_ready = 0; tbre = 1; tsre = 1; uart_rx = 16'h0055;

    //           is_if we addr       wdata    dr tb ts exp       lat   {ce,oe,we,den,rdn,wrn}
    vecs[0]  = '{1'b1, 1'b0, 18'h00040, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[1]  = '{1'b0, 1'b0, 18'h00100, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 3, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2]  = '{1'b0, 1'b1, 18'h08000, 16'hA5A5, 1'b0, 1'b1, 1'b1, 16'h0000, 5, {8'd4, 8'd0, 8'd2, 8'd4, 8'd0, 8'd0}};
    vecs[3]  = '{1'b0, 1'b0, 18'h08000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA5A5, 3, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4]  = '{1'b0, 1'b0, 18'h0BF01, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5]  = '{1'b0, 1'b1, 18'h0BF01, 16'h9999, 1'b0, 1'b1, 1'b1, 16'h0000, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[6]  = '{1'b0, 1'b0, 18'h0BF01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[7]  = '{1'b1, 1'b0, 18'h0BF00, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h7777, 3, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[8]  = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hC0DE, 3, {8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[9]  = '{1'b0, 1'b0, 18'h0BF00, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0055, 4, {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0}};
    vecs[10] = '{1'b0, 1'b1, 18'h0BF00, 16'h0033, 1'b0, 1'b1, 1'b1, 16'h0000, 3, {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1}};

    #1;
    chk("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn, sram_dout_en}, 6'b111110);
    chk("reset_pulses", {if_valid, mem_done, stall_o}, 3'b000);
    chk("reset_addr_dout", {sram_addr, sram_dout}, 34'h0);
    chk("reset_rdata", {if_inst, mem_rdata}, 32'h0);
    tick(); tick();
    rst = 0;
    tick();

    // reset in the middle of the write pulse abandons the store
    s_done = c_done;
    mem_req = 1; mem_we = 1; mem_addr = 18'h00200; mem_wdata = 16'h1111;
    tick(); tick();
    chk("pre_rst_we_low", sram_we_n, 1'b0);
    #3 rst = 1;
    #1;
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_ce_dout_en", {sram_ce_n, sram_dout_en}, 2'b10);
    chk("rst_stall", stall_o, 1'b0);
    mem_req = 0; mem_we = 0;
    tick();
    rst = 0;
    repeat (4) tick();
    chk("rst_no_done", c_done - s_done, 0);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      data_ready = v.dr; tbre = v.tb; tsre = v.ts;
      s_ce = c_ce; s_oe = c_oe; s_we = c_we; s_den = c_den; s_rdn = c_rdn; s_wrn = c_wrn;
      sb_q.push_back(sb_t'{v.is_if, !v.we, v.exp});
      if (v.is_if) begin
        if_req = 1; if_addr = v.addr[15:0];
      end else begin
        mem_req = 1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      end
      lat = 0; got = 0;
      while (!got && lat < 40) begin
        tick();
        lat++;
        got = v.is_if ? if_valid : mem_done;
      end
      if_req = 0; mem_req = 0; mem_we = 0;
      chk($sformatf("latency_v%0d", i), lat, v.lat);
      chk($sformatf("strobes_v%0d", i),
          {8'(c_ce - s_ce), 8'(c_oe - s_oe), 8'(c_we - s_we), 8'(c_den - s_den), 8'(c_rdn - s_rdn), 8'(c_wrn - s_wrn)},
          v.strobes);
      tick();
      chk($sformatf("stall_idle_v%0d", i), stall_o, 1'b0);
    end

    // simultaneous requests: MEM first, then IF, stall held throughout
    data_ready = 0;
    sb_q.push_back(sb_t'{1'b0, 1'b1, 16'hBEEF});
    sb_q.push_back(sb_t'{1'b1, 1'b1, 16'h1234});
    mem_req = 1; mem_we = 0; mem_addr = 18'h00100;
    if_req = 1; if_addr = 16'h0040;
    st = 0; mem_at = 0; if_at = 0;
    for (int c = 1; c <= 30 && if_at == 0; c++) begin
      tick();
      if (stall_o) st++;
      if (mem_done) begin mem_at = c; mem_req = 0; end
      if (if_valid) begin if_at = c; if_req = 0; end
    end
    if_req = 0; mem_req = 0;
    chk("simul_mem_cycle", mem_at, 3);
    chk("simul_if_cycle", if_at, 6);
    chk("simul_stall_cycles", st, 6);
    tick();

    // UART store: tbre rises 5 cycles after wrn falls, tsre 3 cycles later
    tbre = 0; tsre = 0;
    s_ce = c_ce; s_wrn = c_wrn;
    sb_q.push_back(sb_t'{1'b0, 1'b0, 16'h0000});
    mem_req = 1; mem_we = 1; mem_addr = 18'h0BF00; mem_wdata = 16'h0041;
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      tick();
      if (c == 6) tbre = 1;
      if (c == 9) tsre = 1;
      if (mem_done) lat = c;
    end
    mem_req = 0; mem_we = 0;
    chk("uwr_done_cycle", lat, 10);
    chk("uwr_wrn_cycles", c_wrn - s_wrn, 1);
    chk("uwr_ce_cycles", c_ce - s_ce, 0);
    chk("uwr_tx_data", uart_tx, 16'h0041);
    tick();

    chk("ce_uart_overlap", c_ovl, 0);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
